// File: rtl/grf_write_arbiter.sv
// grf_write_arbiter: shares the GRF write port between the W stage and buffered LU results, with a busy scoreboard
// Ports:
//   clk, reset (async, active-low)
//   issue_valid/issue_rd -> issue_ready : LU issue handshake, gated by scoreboard and outstanding limit
//   pipe_we/pipe_a3/pipe_wd              : W-stage write request, always has priority
//   lu_valid/lu_rd/lu_wd -> lu_ready     : LU result handshake into the result FIFO
//   grf_we/grf_a3/grf_wd                 : GRF write port
//   busy                                 : per-register pending-LU-write scoreboard (bit 0 always 0)
//   pipe_hold                            : registered one-cycle request to idle the W stage
module grf_write_arbiter #(
  parameter int DEPTH        = 2,
  parameter int MAX_OUT      = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  output logic        issue_ready,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_a3,
  input  logic [31:0] pipe_wd,
  input  logic        lu_valid,
  input  logic [4:0]  lu_rd,
  input  logic [31:0] lu_wd,
  output logic        lu_ready,
  output logic        grf_we,
  output logic [4:0]  grf_a3,
  output logic [31:0] grf_wd,
  output logic [31:0] busy,
  output logic        pipe_hold
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]    rd_mem_q [DEPTH];
  logic [4:0]    rd_mem_d [DEPTH];
  logic [31:0]   wd_mem_q [DEPTH];
  logic [31:0]   wd_mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [OW-1:0] outstanding_q, outstanding_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [31:0]   busy_q, busy_d;
  logic          hold_q, hold_d;
  logic          full, empty, push, pop, issue_acc, blocked;
  logic [4:0]    head_rd;
  logic [31:0]   head_wd;

  always_comb begin
    full        = count_q == CW'(DEPTH);
    empty       = count_q == '0;
    head_rd     = rd_mem_q[rd_ptr_q];
    head_wd     = wd_mem_q[rd_ptr_q];
    lu_ready    = !full;
    push        = lu_valid && !full;
    // W stage always wins; the buffer head only drains in idle W-stage cycles
    pop         = !pipe_we && !empty;
    blocked     = pipe_we && !empty;
    issue_ready = !busy_q[issue_rd] && outstanding_q < OW'(MAX_OUT);
    issue_acc   = issue_valid && issue_ready;
    grf_we      = pipe_we || !empty;
    grf_a3      = pipe_we ? pipe_a3 : empty ? 5'd0 : head_rd;
    grf_wd      = pipe_we ? pipe_wd : empty ? 32'd0 : head_wd;
    busy        = busy_q;
    pipe_hold   = hold_q;
    rd_mem_d    = rd_mem_q;
    wd_mem_d    = wd_mem_q;
    if (push) begin
      rd_mem_d[wr_ptr_q] = lu_rd;
      wd_mem_d[wr_ptr_q] = lu_wd;
    end
    wr_ptr_d      = wr_ptr_q + PW'(push);
    rd_ptr_d      = rd_ptr_q + PW'(pop);
    count_d       = count_q + CW'(push) - CW'(pop);
    outstanding_d = outstanding_q + OW'(issue_acc) - OW'(pop);
    // issue to a busy register is refused, so set and clear never target the same bit
    busy_d = busy_q;
    if (pop) busy_d[head_rd] = 1'b0;
    if (issue_acc) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
    // saturate so a W stage ignoring pipe_hold cannot wrap the counter
    starve_d = pop ? '0 : (blocked && starve_q != SW'(STARVE_LIMIT)) ? starve_q + SW'(1) : starve_q;
    hold_d   = !hold_q && blocked && starve_q == SW'(STARVE_LIMIT - 1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_mem_q      <= '{default: '0};
      wd_mem_q      <= '{default: '0};
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      starve_q      <= '0;
      busy_q        <= '0;
      hold_q        <= 1'b0;
    end else begin
      rd_mem_q      <= rd_mem_d;
      wd_mem_q      <= wd_mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      starve_q      <= starve_d;
      busy_q        <= busy_d;
      hold_q        <= hold_d;
    end
  end
endmodule

// File: tb/tb_grf_write_arbiter.sv
// tb_grf_write_arbiter: directed and random checks of grf_write_arbiter against a queue-based reference model
module tb_grf_write_arbiter;
  localparam int DEPTH = 2;
  localparam int MAX_OUT = 4;
  localparam int STARVE_LIMIT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid, issue_ready;
  logic [4:0]  issue_rd;
  logic        pipe_we;
  logic [4:0]  pipe_a3;
  logic [31:0] pipe_wd;
  logic        lu_valid, lu_ready;
  logic [4:0]  lu_rd;
  logic [31:0] lu_wd;
  logic        grf_we;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd;
  logic [31:0] busy;
  logic        pipe_hold;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] bz;
  int          outst, starve_m;
  bit          hold_m;
  logic [4:0]  q_rd[$];
  logic [31:0] q_wd[$];
  logic [4:0]  inflight[$];

  grf_write_arbiter #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .pipe_we(pipe_we), .pipe_a3(pipe_a3), .pipe_wd(pipe_wd),
    .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_wd(lu_wd), .lu_ready(lu_ready),
    .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd),
    .busy(busy), .pipe_hold(pipe_hold)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    bz = '0;
    outst = 0;
    starve_m = 0;
    hold_m = 0;
    q_rd.delete();
    q_wd.delete();
    inflight.delete();
  endtask

  // checks every output against the model mid-cycle, then advances the model across the edge
  task automatic step();
    bit e_ir, e_lr, e_we, acc, pop, push, blk, nhold;
    logic [4:0]  e_a3;
    logic [31:0] e_wd;
    @(negedge clk);
    e_ir = !bz[issue_rd] && outst < MAX_OUT;
    e_lr = q_rd.size() < DEPTH;
    e_we = pipe_we || q_rd.size() > 0;
    e_a3 = pipe_we ? pipe_a3 : (q_rd.size() > 0 ? q_rd[0] : 5'd0);
    e_wd = pipe_we ? pipe_wd : (q_wd.size() > 0 ? q_wd[0] : 32'd0);
    chk("issue_ready", issue_ready, e_ir);
    chk("lu_ready", lu_ready, e_lr);
    chk("grf_we", grf_we, e_we);
    chk("grf_a3", grf_a3, e_a3);
    chk("grf_wd", grf_wd, e_wd);
    chk("busy", busy, bz);
    chk("pipe_hold", pipe_hold, hold_m);
    if (pipe_we) chk("busy_at_pipe_write", busy[pipe_a3], 0);
    acc = issue_valid && e_ir;
    pop = !pipe_we && q_rd.size() > 0;
    push = lu_valid && e_lr;
    blk = pipe_we && q_rd.size() > 0;
    nhold = !hold_m && blk && starve_m == STARVE_LIMIT - 1;
    if (pop) begin
      bz[q_rd[0]] = 1'b0;
      void'(q_rd.pop_front());
      void'(q_wd.pop_front());
      outst--;
      starve_m = 0;
    end else if (blk) starve_m++;
    if (acc) begin
      outst++;
      if (issue_rd != 0) bz[issue_rd] = 1'b1;
    end
    bz[0] = 1'b0;
    if (push) begin
      q_rd.push_back(lu_rd);
      q_wd.push_back(lu_wd);
    end
    hold_m = nhold;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_issue_ready", issue_ready, 1);
    chk("rst_lu_ready", lu_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_pipe_hold", pipe_hold, 0);
    chk("rst_grf_we", grf_we, pipe_we);
    chk("rst_grf_a3", grf_a3, pipe_we ? pipe_a3 : 5'd0);
    chk("rst_grf_wd", grf_wd, pipe_we ? pipe_wd : 32'd0);
    clear_model();
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
  endtask

  initial begin
    bit iss_ok, lu_ok;
    int idx;
    reset = 1'b1;
    issue_valid = 0; issue_rd = 0;
    pipe_we = 0; pipe_a3 = 0; pipe_wd = 0;
    lu_valid = 0; lu_rd = 0; lu_wd = 0;
    clear_model();
    #2;
    do_reset();

    // issue, return, write, busy clear; duplicate issue and rd 0
    issue_valid = 1; issue_rd = 5; step();
    issue_valid = 0; #1 chk("busy5_set", busy[5], 1);
    issue_valid = 1; issue_rd = 5; #1 chk("dup_issue_refused", issue_ready, 0);
    step();
    issue_rd = 0; step();
    issue_valid = 0;
    lu_valid = 1; lu_rd = 5; lu_wd = 32'h1234; step();
    lu_valid = 0; #1;
    chk("lu_write_we", grf_we, 1);
    chk("lu_write_a3", grf_a3, 5);
    chk("lu_write_wd", grf_wd, 32'h1234);
    step();
    chk("busy5_clear", busy[5], 0);
    lu_valid = 1; lu_rd = 0; lu_wd = 32'h55; step();
    lu_valid = 0; #1;
    chk("rd0_write_we", grf_we, 1);
    chk("rd0_write_a3", grf_a3, 0);
    step();

    // outstanding limit
    do_reset();
    for (int r = 1; r <= 4; r++) begin
      issue_valid = 1; issue_rd = 5'(r); step();
    end
    issue_rd = 6; #1 chk("max_out_refused", issue_ready, 0);
    step(); step();
    issue_valid = 0;
    lu_valid = 1; lu_rd = 1; lu_wd = 32'hCAFE; step();
    lu_valid = 0; step();
    issue_valid = 1; issue_rd = 6; #1 chk("max_out_freed", issue_ready, 1);
    step();
    issue_valid = 0;

    // buffer fill under continuous W-stage writes, starvation hold
    pipe_we = 1; pipe_a3 = 10; pipe_wd = 32'hA5A5;
    lu_valid = 1; lu_rd = 2; lu_wd = 32'h22; step();
    lu_rd = 3; lu_wd = 32'h33; step();
    lu_valid = 0; #1 chk("full_lu_ready", lu_ready, 0);
    step(); step();
    chk("starve_hold", pipe_hold, 1);
    pipe_we = 0; #1 chk("starve_head_a3", grf_a3, 2);
    step();
    chk("hold_one_cycle", pipe_hold, 0);
    step();

    // pipeline priority over buffered head
    do_reset();
    issue_valid = 1; issue_rd = 9; step();
    issue_valid = 0;
    pipe_we = 1; pipe_a3 = 7; pipe_wd = 32'hAA;
    lu_valid = 1; lu_rd = 9; lu_wd = 32'h99; step();
    lu_valid = 0; #1;
    chk("prio_pipe_a3", grf_a3, 7);
    chk("prio_pipe_wd", grf_wd, 32'hAA);
    step();
    pipe_we = 0; #1;
    chk("prio_head_a3", grf_a3, 9);
    chk("prio_head_wd", grf_wd, 32'h99);
    step();

    // reset with buffered results and busy bits
    do_reset();
    issue_valid = 1; issue_rd = 11; step();
    issue_rd = 12; step();
    issue_valid = 0;
    pipe_we = 1; pipe_a3 = 3; pipe_wd = 32'h3;
    lu_valid = 1; lu_rd = 11; lu_wd = 32'hB; step();
    lu_rd = 12; lu_wd = 32'hC; step();
    lu_valid = 0;
    do_reset();
    pipe_we = 0;
    step(); step(); step();

    // random traffic obeying the hazard and hold contracts
    do_reset();
    for (int c = 0; c < 600; c++) begin
      issue_valid = $urandom_range(0, 2) == 0;
      issue_rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 8));
      lu_valid = inflight.size() > 0 && $urandom_range(0, 1) == 1;
      idx = inflight.size() > 0 ? int'($urandom_range(0, inflight.size() - 1)) : 0;
      lu_rd = lu_valid ? inflight[idx] : 5'd0;
      lu_wd = $urandom;
      pipe_a3 = 5'($urandom_range(0, 31));
      pipe_wd = $urandom;
      pipe_we = !hold_m && !bz[pipe_a3] && $urandom_range(0, 2) != 0;
      iss_ok = issue_valid && !bz[issue_rd] && outst < MAX_OUT;
      lu_ok = lu_valid && q_rd.size() < DEPTH;
      step();
      if (lu_ok) inflight.delete(idx);
      if (iss_ok) inflight.push_back(issue_rd);
    end
    issue_valid = 0; pipe_we = 0;
    for (int c = 0; c < 30; c++) begin
      lu_valid = inflight.size() > 0;
      lu_rd = lu_valid ? inflight[0] : 5'd0;
      lu_wd = $urandom;
      lu_ok = lu_valid && q_rd.size() < DEPTH;
      step();
      if (lu_ok) void'(inflight.pop_front());
    end
    chk("drain_busy", busy, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
